// File: rtl/systolic_loader.sv
// Tile loader: takes an A-then-B word stream and scatters it lane-interleaved
// across per-lane bank pairs, then hands the tile to the scheduler via start.
module systolic_loader #(
  parameter int L      = 8,
  parameter int ENTRYS = 1024,
  parameter int WIDTH  = 32,
  parameter int KW     = $clog2(ENTRYS) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_valid,
  input  logic [KW-1:0]             cfg_k,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_last,
  output logic [L-1:0]              wr_a_en,
  output logic [L-1:0]              wr_b_en,
  output logic [$clog2(ENTRYS)-1:0] wr_addr,
  output logic [WIDTH-1:0]          wr_data,
  output logic                      start,
  input  logic                      compute_done,
  output logic                      busy,
  output logic                      err,
  output logic [2:0]                dbg_state
);

  localparam int AW = $clog2(ENTRYS);
  localparam int LW = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_FIRE   = 3'd3,
    S_WAIT   = 3'd4
  } state_e;

  // Handshake: a word transfers on a rising clk edge where in_valid && in_ready;
  // in_data/in_last must be stable while in_valid is high, in_ready is registered.
  state_e            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [LW-1:0]     lane_q, lane_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              in_ready_q, in_ready_d;
  logic [L-1:0]      wr_a_en_q, wr_a_en_d;
  logic [L-1:0]      wr_b_en_q, wr_b_en_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]  wr_data_q, wr_data_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic              beat;
  logic              last_beat;
  logic [L-1:0]      lane_onehot;

  assign beat        = in_valid && in_ready_q;
  assign last_beat   = (lane_q == LW'(L - 1)) && ({1'b0, addr_q} == (k_q - KW'(1)));
  assign lane_onehot = L'(1) << lane_q;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    lane_d     = lane_q;
    addr_d     = addr_q;
    in_ready_d = in_ready_q;
    wr_a_en_d  = '0;
    wr_b_en_d  = '0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    start_d    = 1'b0;
    busy_d     = busy_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          if ((cfg_k != '0) && (cfg_k <= KW'(ENTRYS))) begin
            k_d        = cfg_k;
            lane_d     = '0;
            addr_d     = '0;
            state_d    = S_LOAD_A;
            in_ready_d = 1'b1;
            busy_d     = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD_A, S_LOAD_B: begin
        if (beat) begin
          if (state_q == S_LOAD_A) wr_a_en_d = lane_onehot;
          else                     wr_b_en_d = lane_onehot;
          wr_addr_d = addr_q;
          wr_data_d = in_data;
          // in_last only flags framing; the beat count alone ends the tile
          if (in_last != ((state_q == S_LOAD_B) && last_beat)) err_d = 1'b1;
          if (last_beat) begin
            lane_d = '0;
            addr_d = '0;
            if (state_q == S_LOAD_A) begin
              state_d = S_LOAD_B;
            end else begin
              state_d    = S_FIRE;
              in_ready_d = 1'b0;
            end
          end else if (lane_q == LW'(L - 1)) begin
            lane_d = '0;
            addr_d = addr_q + AW'(1);
          end else begin
            lane_d = lane_q + LW'(1);
          end
        end
      end
      S_FIRE: begin
        // First FIRE cycle lets the final bank write commit; second raises start
        if (!start_q) start_d = 1'b1;
        else          state_d = S_WAIT;
      end
      S_WAIT: begin
        if (compute_done) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d    = S_IDLE;
        in_ready_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      lane_q     <= '0;
      addr_q     <= '0;
      in_ready_q <= 1'b0;
      wr_a_en_q  <= '0;
      wr_b_en_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      lane_q     <= lane_d;
      addr_q     <= addr_d;
      in_ready_q <= in_ready_d;
      wr_a_en_q  <= wr_a_en_d;
      wr_b_en_q  <= wr_b_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign wr_a_en   = wr_a_en_q;
  assign wr_b_en   = wr_b_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign start     = start_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_systolic_loader.sv
// Directed bench for systolic_loader: bank model fed from the write ports,
// hand-computed expectations checked with immediate assertions.
module tb_systolic_loader;

  localparam int L      = 8;
  localparam int ENTRYS = 1024;
  localparam int WIDTH  = 32;
  localparam int KW     = $clog2(ENTRYS) + 1;
  localparam int AW     = $clog2(ENTRYS);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_A = 3'd1;
  localparam logic [2:0] ST_LOAD_B = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [KW-1:0]    cfg_k = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic [L-1:0]     wr_a_en;
  logic [L-1:0]     wr_b_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             start;
  logic             compute_done = 1'b0;
  logic             busy;
  logic             err;
  logic [2:0]       dbg_state;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] a_mem [0:L-1][0:ENTRYS-1];
  logic [WIDTH-1:0] b_mem [0:L-1][0:ENTRYS-1];
  int  wr_cnt    = 0;
  int  start_cnt = 0;
  int  stray_cnt = 0;
  int  multi_cnt = 0;
  logic hs_prev  = 1'b0;

  systolic_loader #(.L(L), .ENTRYS(ENTRYS), .WIDTH(WIDTH), .KW(KW)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_k(cfg_k),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .wr_a_en(wr_a_en), .wr_b_en(wr_b_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .compute_done(compute_done), .busy(busy), .err(err),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Bank model: captures whatever the write ports present at each edge
  always @(posedge clk) begin
    if (((wr_a_en | wr_b_en) != '0) && !hs_prev) stray_cnt++;
    if (!$onehot0({wr_a_en, wr_b_en})) multi_cnt++;
    for (int i = 0; i < L; i++) begin
      if (wr_a_en[i]) begin a_mem[i][wr_addr] = wr_data; wr_cnt++; end
      if (wr_b_en[i]) begin b_mem[i][wr_addr] = wr_data; wr_cnt++; end
    end
    if (start) start_cnt++;
    hs_prev = in_valid && in_ready && rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < L; i++)
      for (int j = 0; j < ENTRYS; j++) begin
        a_mem[i][j] = '0;
        b_mem[i][j] = '0;
      end
  endtask

  task automatic do_cfg(input int k);
    cfg_valid = 1'b1;
    cfg_k     = KW'(k);
    tick();
    cfg_valid = 1'b0;
    cfg_k     = '0;
  endtask

  task automatic send_beat(input logic [WIDTH-1:0] d, input logic l, input int gap);
    int w;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    w = 0;
    while (!in_ready && w < 20) begin tick(); w++; end
    chk("beat_accept_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic finish_tile();
    tick();
    tick();
    compute_done = 1'b1;
    tick();
    compute_done = 1'b0;
  endtask

  initial begin
    int bad;
    int s0;
    int w0;
    clear_mem();

    // Reset state
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_a_en", wr_a_en, 0);
    chk("rst_wr_b_en", wr_b_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    rst = 1'b1;
    tick();

    // Basic tile K=2
    do_cfg(2);
    chk("t1_ready_after_cfg", in_ready, 1);
    chk("t1_busy", busy, 1);
    chk("t1_state_load_a", dbg_state, ST_LOAD_A);
    for (int n = 0; n < 16; n++) send_beat(WIDTH'(n), 1'b0, 0);
    chk("t1_state_load_b", dbg_state, ST_LOAD_B);
    for (int n = 0; n < 16; n++) send_beat(WIDTH'(100 + n), n == 15, 0);
    chk("t1_start_t", start, 0);
    tick();
    chk("t1_start_t1", start, 1);
    tick();
    chk("t1_start_t2", start, 0);
    chk("t1_state_wait", dbg_state, ST_WAIT);
    chk("t1_a_l3_a1", a_mem[3][1], 11);
    chk("t1_b_l7_a0", b_mem[7][0], 107);
    chk("t1_b_l7_a1", b_mem[7][1], 115);
    chk("t1_wr_cnt", wr_cnt, 32);
    repeat (4) tick();
    chk("t1_busy_in_wait", busy, 1);
    chk("t1_start_cnt", start_cnt, 1);
    chk("t1_err", err, 0);
    compute_done = 1'b1;
    tick();
    compute_done = 1'b0;
    chk("t1_busy_done", busy, 0);
    chk("t1_state_idle", dbg_state, ST_IDLE);
    chk("t1_ready_idle", in_ready, 0);

    // Same tile with random in_valid gaps
    clear_mem();
    w0 = wr_cnt;
    do_cfg(2);
    for (int n = 0; n < 16; n++) send_beat(WIDTH'(n), 1'b0, $urandom_range(0, 3));
    for (int n = 0; n < 16; n++) send_beat(WIDTH'(100 + n), n == 15, $urandom_range(0, 3));
    finish_tile();
    bad = 0;
    for (int n = 0; n < 16; n++) begin
      if (a_mem[n % L][n / L] !== WIDTH'(n)) bad++;
      if (b_mem[n % L][n / L] !== WIDTH'(100 + n)) bad++;
    end
    chk("t2_bank_contents", bad, 0);
    chk("t2_wr_cnt", wr_cnt - w0, 32);
    chk("t2_stray_enables", stray_cnt, 0);
    chk("t2_start_cnt", start_cnt, 2);
    chk("t2_err", err, 0);

    // in_last on A beat 5
    do_cfg(2);
    for (int n = 0; n < 16; n++) begin
      send_beat(WIDTH'(n), n == 5, 0);
      if (n == 4) chk("t3_err_before", err, 0);
      if (n == 5) chk("t3_err_after", err, 1);
    end
    for (int n = 0; n < 16; n++) send_beat(WIDTH'(100 + n), n == 15, 0);
    tick();
    chk("t3_start_still", start, 1);
    tick();
    compute_done = 1'b1;
    tick();
    compute_done = 1'b0;
    chk("t3_start_cnt", start_cnt, 3);
    chk("t3_err_sticky", err, 1);

    // Illegal cfg_k values
    rst = 1'b0; tick(); rst = 1'b1; tick();
    chk("t4_err_cleared", err, 0);
    w0 = wr_cnt;
    do_cfg(0);
    chk("t4_k0_err", err, 1);
    chk("t4_k0_state", dbg_state, ST_IDLE);
    chk("t4_k0_ready", in_ready, 0);
    rst = 1'b0; tick(); rst = 1'b1; tick();
    do_cfg(ENTRYS + 1);
    chk("t4_kbig_err", err, 1);
    chk("t4_kbig_state", dbg_state, ST_IDLE);
    chk("t4_kbig_ready", in_ready, 0);
    chk("t4_kbig_busy", busy, 0);
    repeat (2) tick();
    chk("t4_no_writes", wr_cnt - w0, 0);

    // Reset during LOAD_B beat 3
    rst = 1'b0; tick(); rst = 1'b1; tick();
    clear_mem();
    s0 = start_cnt;
    do_cfg(2);
    for (int n = 0; n < 16; n++) send_beat(WIDTH'(n), 1'b0, 0);
    for (int n = 0; n < 3; n++) send_beat(WIDTH'(100 + n), 1'b0, 0);
    in_valid = 1'b1;
    in_data  = 103;
    rst = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("t5_ready", in_ready, 0);
    chk("t5_wr_a_en", wr_a_en, 0);
    chk("t5_wr_b_en", wr_b_en, 0);
    chk("t5_wr_addr", wr_addr, 0);
    chk("t5_wr_data", wr_data, 0);
    chk("t5_busy", busy, 0);
    chk("t5_state", dbg_state, ST_IDLE);
    tick();
    rst = 1'b1;
    repeat (4) tick();
    chk("t5_no_start", start_cnt - s0, 0);
    chk("t5_committed_b2", b_mem[2][0], 102);
    chk("t5_beat3_dropped", b_mem[3][0], 0);
    do_cfg(2);
    for (int n = 0; n < 16; n++) send_beat(WIDTH'(200 + n), 1'b0, 0);
    for (int n = 0; n < 16; n++) send_beat(WIDTH'(300 + n), n == 15, 0);
    finish_tile();
    chk("t5_fresh_a_l3_a1", a_mem[3][1], 211);
    chk("t5_fresh_b_l3_a0", b_mem[3][0], 303);
    chk("t5_fresh_b_l7_a1", b_mem[7][1], 315);
    chk("t5_fresh_start", start_cnt - s0, 1);
    chk("t5_fresh_err", err, 0);

    // K=ENTRYS tile with compute_done during LOAD_A
    do_cfg(ENTRYS);
    for (int n = 0; n < L * ENTRYS; n++) begin
      send_beat(WIDTH'(n), 1'b0, 0);
      if (n == 9) begin
        compute_done = 1'b1;
        tick();
        compute_done = 1'b0;
        chk("t6_cd_ignored_state", dbg_state, ST_LOAD_A);
        chk("t6_cd_ignored_ready", in_ready, 1);
      end
    end
    chk("t6_last_a_addr", wr_addr, ENTRYS - 1);
    chk("t6_last_a_lane", wr_a_en, 8'h80);
    chk("t6_state_load_b", dbg_state, ST_LOAD_B);
    for (int n = 0; n < L * ENTRYS; n++) begin
      send_beat(WIDTH'(32'h10000 + n), n == L * ENTRYS - 1, 0);
      if (n == 0) begin
        chk("t6_first_b_addr", wr_addr, 0);
        chk("t6_first_b_lane", wr_b_en, 8'h01);
      end
    end
    finish_tile();
    chk("t6_a_l7_top", a_mem[7][ENTRYS-1], L * ENTRYS - 1);
    chk("t6_b_l0_a0", b_mem[0][0], 32'h10000);
    chk("t6_b_l7_top", b_mem[7][ENTRYS-1], 32'h10000 + L * ENTRYS - 1);
    chk("t6_state_idle", dbg_state, ST_IDLE);
    chk("t6_err", err, 0);
    chk("all_multi_hot", multi_cnt, 0);
    chk("all_stray_enables", stray_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
